// File: rtl/axis_rx_fifo_if.sv
`default_nettype none
// ============================================================================
// Module   : axis_rx_fifo_if
// Brief    : AXI-Stream beat channel (data, strobes, last, user) with handshake.
// Revision : 1.0 - initial release
// ============================================================================
interface axis_rx_fifo_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                    TVALID;
    logic                    TREADY;
    logic [DATA_WIDTH-1:0]   TDATA;
    logic [DATA_WIDTH/8-1:0] TSTRB;
    logic                    TLAST;
    logic                    TUSER;

    modport master (
        output TVALID,
        output TDATA,
        output TSTRB,
        output TLAST,
        output TUSER,
        input  TREADY
    );

    modport slave (
        input  TVALID,
        input  TDATA,
        input  TSTRB,
        input  TLAST,
        input  TUSER,
        output TREADY
    );
endinterface
`default_nettype wire

// File: rtl/axis_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : axis_rx_fifo
// Brief    : AXI-Stream receive FIFO (first-word fall-through) with per-packet
//            byte counting and error reporting on the write side.
// Revision : 1.0 - initial release
// ============================================================================
module axis_rx_fifo #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 16
) (
    input  wire logic                      ACLK,
    input  wire logic                      ARESETn,
    axis_rx_fifo_if.slave                  s_axis,
    input  wire logic                      rd_en,
    output logic                           rd_valid,
    output logic [DATA_WIDTH-1:0]          rd_data,
    output logic [DATA_WIDTH/8-1:0]        rd_strb,
    output logic                           rd_last,
    output logic                           pkt_done,
    output logic [15:0]                    pkt_bytes,
    output logic                           pkt_err,
    output logic [$clog2(DEPTH):0]         level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned SW = DATA_WIDTH / 8;
    localparam int unsigned EW = 1 + SW + DATA_WIDTH;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BODY = 1'b1
    } state_t;

    state_t          state;
    state_t          state_nxt;

    logic [EW-1:0]   mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            ready_en;
    logic            push;
    logic            pop;

    logic [15:0]     acc;
    logic            err_flag;
    logic [15:0]     beat_bytes;
    logic [16:0]     sum_raw;
    logic [15:0]     sum_sat;

    function automatic logic [15:0] popcount(input logic [SW-1:0] v);
        logic [15:0] c;
        c = '0;
        for (int i = 0; i < int'(SW); i++) begin
            c = c + 16'(v[i]);
        end
        return c;
    endfunction

    // ready_en keeps TREADY low until the first edge after reset release
    assign s_axis.TREADY = ready_en && (level < LW'(DEPTH));
    assign push          = s_axis.TVALID && s_axis.TREADY;
    assign rd_valid      = (level != '0);
    assign pop           = rd_en && rd_valid;

    assign {rd_last, rd_strb, rd_data} = mem[rd_ptr];

    always_ff @(posedge ACLK) begin
        if (push) begin
            mem[wr_ptr] <= {s_axis.TLAST, s_axis.TSTRB, s_axis.TDATA};
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (push) begin
            state_nxt = s_axis.TLAST ? ST_IDLE : ST_BODY;
        end
    end

    // Packet accounting runs purely off accepted beats, never off the read side
    assign beat_bytes = popcount(s_axis.TSTRB);
    assign sum_raw    = {1'b0, acc} + {1'b0, beat_bytes};
    assign sum_sat    = sum_raw[16] ? 16'hFFFF : sum_raw[15:0];

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            acc       <= '0;
            err_flag  <= 1'b0;
            pkt_done  <= 1'b0;
            pkt_bytes <= '0;
            pkt_err   <= 1'b0;
        end else begin
            pkt_done <= push && s_axis.TLAST;
            if (push) begin
                if (s_axis.TLAST) begin
                    pkt_bytes <= sum_sat;
                    pkt_err   <= err_flag || s_axis.TUSER;
                    acc       <= '0;
                    err_flag  <= 1'b0;
                end else begin
                    acc       <= sum_sat;
                    err_flag  <= err_flag || s_axis.TUSER;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axis_rx_fifo.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_axis_rx_fifo
// Brief    : Directed self-checking bench for axis_rx_fifo (DATA_WIDTH=32, DEPTH=16).
// Revision : 1.0 - initial release
// ============================================================================
module tb_axis_rx_fifo;

    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned DEPTH      = 16;

    logic        clk;
    logic        rst_n;
    logic        rd_en;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic [3:0]  rd_strb;
    logic        rd_last;
    logic        pkt_done;
    logic [15:0] pkt_bytes;
    logic        pkt_err;
    logic [4:0]  level;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] exp_q [$];

    axis_rx_fifo_if #(.DATA_WIDTH(DATA_WIDTH)) s_axis ();

    axis_rx_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) dut (
        .ACLK      (clk),
        .ARESETn   (rst_n),
        .s_axis    (s_axis),
        .rd_en     (rd_en),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .rd_strb   (rd_strb),
        .rd_last   (rd_last),
        .pkt_done  (pkt_done),
        .pkt_bytes (pkt_bytes),
        .pkt_err   (pkt_err),
        .level     (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] d, input logic [3:0] s, input logic l, input logic u);
        s_axis.TVALID = 1'b1;
        s_axis.TDATA  = d;
        s_axis.TSTRB  = s;
        s_axis.TLAST  = l;
        s_axis.TUSER  = u;
    endtask

    task automatic idle_in();
        s_axis.TVALID = 1'b0;
        s_axis.TDATA  = '0;
        s_axis.TSTRB  = '0;
        s_axis.TLAST  = 1'b0;
        s_axis.TUSER  = 1'b0;
    endtask

    task automatic drain_check(input string tag);
        while (exp_q.size() > 0) begin
            check_value(tag, rd_data, exp_q.pop_front());
            rd_en = 1'b1;
            step();
        end
        rd_en = 1'b0;
        check_value({tag, "_empty"}, {31'd0, rd_valid}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        rd_en = 1'b0;
        idle_in();
        #1;
        check_value("rst_tready", {31'd0, s_axis.TREADY}, 32'd0);
        check_value("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
        check_value("rst_pkt_done", {31'd0, pkt_done}, 32'd0);
        check_value("rst_pkt_bytes", {16'd0, pkt_bytes}, 32'd0);
        check_value("rst_pkt_err", {31'd0, pkt_err}, 32'd0);
        check_value("rst_level", {27'd0, level}, 32'd0);
        step();
        step();
        rst_n = 1'b1;
        step();
        check_value("post_rst_tready", {31'd0, s_axis.TREADY}, 32'd1);

        // single beat packet
        drive(32'hA5A5A5A5, 4'hF, 1'b1, 1'b0);
        step();
        idle_in();
        check_value("sb_rd_valid", {31'd0, rd_valid}, 32'd1);
        check_value("sb_rd_data", rd_data, 32'hA5A5A5A5);
        check_value("sb_rd_last", {31'd0, rd_last}, 32'd1);
        check_value("sb_pkt_done", {31'd0, pkt_done}, 32'd1);
        check_value("sb_pkt_bytes", {16'd0, pkt_bytes}, 32'd4);
        check_value("sb_pkt_err", {31'd0, pkt_err}, 32'd0);
        check_value("sb_level", {27'd0, level}, 32'd1);
        step();
        check_value("sb_done_pulse", {31'd0, pkt_done}, 32'd0);
        check_value("sb_bytes_held", {16'd0, pkt_bytes}, 32'd4);
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        check_value("sb_pop_level", {27'd0, level}, 32'd0);
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        check_value("empty_pop_ignored", {27'd0, level}, 32'd0);

        // four-beat packet with error on beat 2
        for (int k = 0; k < 4; k++) begin
            drive(32'h11111111 * (k + 1), (k == 3) ? 4'h3 : 4'hF, k == 3, k == 1);
            exp_q.push_back(32'h11111111 * (k + 1));
            step();
            if (k == 2) check_value("p4_no_early_done", {31'd0, pkt_done}, 32'd0);
        end
        idle_in();
        check_value("p4_pkt_done", {31'd0, pkt_done}, 32'd1);
        check_value("p4_pkt_bytes", {16'd0, pkt_bytes}, 32'd14);
        check_value("p4_pkt_err", {31'd0, pkt_err}, 32'd1);
        check_value("p4_level", {27'd0, level}, 32'd4);
        drain_check("p4_data");

        // back-to-back single-beat packets
        drive(32'h0000_00B1, 4'h3, 1'b1, 1'b0);
        exp_q.push_back(32'h0000_00B1);
        step();
        check_value("b2b_done1", {31'd0, pkt_done}, 32'd1);
        check_value("b2b_bytes1", {16'd0, pkt_bytes}, 32'd2);
        check_value("b2b_err1", {31'd0, pkt_err}, 32'd0);
        drive(32'h0000_00B2, 4'hF, 1'b1, 1'b1);
        exp_q.push_back(32'h0000_00B2);
        step();
        idle_in();
        check_value("b2b_done2", {31'd0, pkt_done}, 32'd1);
        check_value("b2b_bytes2", {16'd0, pkt_bytes}, 32'd4);
        check_value("b2b_err2", {31'd0, pkt_err}, 32'd1);
        step();
        check_value("b2b_done_low", {31'd0, pkt_done}, 32'd0);
        check_value("b2b_bytes_held", {16'd0, pkt_bytes}, 32'd4);
        drain_check("b2b_data");

        // fill to full, pop once, accept the 17th beat
        for (int k = 0; k < 16; k++) begin
            drive(32'h100 + k, 4'hF, 1'b0, 1'b0);
            exp_q.push_back(32'h100 + k);
            step();
        end
        check_value("full_level", {27'd0, level}, 32'd16);
        check_value("full_tready", {31'd0, s_axis.TREADY}, 32'd0);
        drive(32'h110, 4'hF, 1'b1, 1'b0);
        rd_en = 1'b1;
        check_value("full_tready_rd_en", {31'd0, s_axis.TREADY}, 32'd0);
        check_value("full_head", rd_data, exp_q.pop_front());
        step();
        rd_en = 1'b0;
        check_value("full_pop_level", {27'd0, level}, 32'd15);
        check_value("full_pop_tready", {31'd0, s_axis.TREADY}, 32'd1);
        exp_q.push_back(32'h110);
        step();
        idle_in();
        check_value("full_17th_level", {27'd0, level}, 32'd16);
        drain_check("full_data");

        // streaming at level 5 with simultaneous push/pop
        for (int k = 0; k < 5; k++) begin
            drive(32'h200 + k, 4'hF, 1'b1, 1'b0);
            exp_q.push_back(32'h200 + k);
            step();
        end
        check_value("stream_start_level", {27'd0, level}, 32'd5);
        for (int k = 0; k < 100; k++) begin
            drive(32'h205 + k, 4'hF, 1'b1, 1'b0);
            rd_en = 1'b1;
            check_value("stream_data", rd_data, exp_q.pop_front());
            exp_q.push_back(32'h205 + k);
            step();
            check_value("stream_level", {27'd0, level}, 32'd5);
        end
        idle_in();
        rd_en = 1'b0;
        drain_check("stream_tail");

        // reset in the middle of a packet
        drive(32'h300, 4'hF, 1'b0, 1'b0);
        step();
        drive(32'h301, 4'hF, 1'b0, 1'b1);
        step();
        idle_in();
        check_value("mid_pre_level", {27'd0, level}, 32'd2);
        rst_n = 1'b0;
        #1;
        check_value("mid_rst_level", {27'd0, level}, 32'd0);
        check_value("mid_rst_rd_valid", {31'd0, rd_valid}, 32'd0);
        check_value("mid_rst_tready", {31'd0, s_axis.TREADY}, 32'd0);
        step();
        rst_n = 1'b1;
        step();
        check_value("mid_no_done", {31'd0, pkt_done}, 32'd0);
        check_value("mid_tready", {31'd0, s_axis.TREADY}, 32'd1);
        drive(32'h400, 4'h1, 1'b1, 1'b0);
        step();
        idle_in();
        check_value("mid_new_done", {31'd0, pkt_done}, 32'd1);
        check_value("mid_new_bytes", {16'd0, pkt_bytes}, 32'd1);
        check_value("mid_new_err", {31'd0, pkt_err}, 32'd0);
        check_value("mid_new_data", rd_data, 32'h400);
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;

        // long packet saturates the byte count
        for (int k = 0; k < 16400; k++) begin
            drive(k, 4'hF, k == 16399, 1'b0);
            rd_en = 1'b1;
            step();
        end
        idle_in();
        check_value("sat_done", {31'd0, pkt_done}, 32'd1);
        check_value("sat_bytes", {16'd0, pkt_bytes}, 32'h0000FFFF);
        check_value("sat_err", {31'd0, pkt_err}, 32'd0);
        check_value("sat_last_data", rd_data, 32'd16399);
        step();
        rd_en = 1'b0;
        check_value("sat_drained", {27'd0, level}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/axis_rx_fifo.md
AXIS_RX_FIFO -- requirements
Module: axis_rx_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 32: TDATA/rd_data width in bits; a multiple of 8.
REQ-002 Parameter DEPTH, default 16: FIFO entries; a power of 2 and >= 2.
REQ-003 ACLK  input  1  single clock; all logic on rising edge.
REQ-004 ARESETn  input  1  asynchronous, active-low reset.
REQ-005 TVALID  input  1  AXI-Stream slave beat valid.
REQ-006 TREADY  output  1  AXI-Stream slave ready.
REQ-007 TDATA  input  DATA_WIDTH  beat data.
REQ-008 TSTRB  input  DATA_WIDTH/8  byte qualifiers.
REQ-009 TLAST  input  1  last beat of packet.
REQ-010 TUSER  input  1  beat error marker.
REQ-011 rd_en  input  1  pop head entry.
REQ-012 rd_valid  output  1  FIFO non-empty; head presented (first-word fall-through).
REQ-013 rd_data  output  DATA_WIDTH  head TDATA.
REQ-014 rd_strb  output  DATA_WIDTH/8  head TSTRB.
REQ-015 rd_last  output  1  head TLAST.
REQ-016 pkt_done  output  1  one-cycle pulse: a packet's last beat was accepted.
REQ-017 pkt_bytes  output  16  byte count of the completed packet; valid while pkt_done=1, held otherwise.
REQ-018 pkt_err  output  1  TUSER seen on any beat of the completed packet; qualified by pkt_done.
REQ-019 level  output  clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-020 Beat accepted on an edge where TVALID=1 and TREADY=1; stored entry = {TLAST, TSTRB, TDATA}; TUSER not stored.
REQ-021 TREADY = (level < DEPTH), decoded from registered occupancy only; no combinational path from rd_en or TVALID to TREADY.
REQ-022 Full: TREADY=0 even if rd_en=1 that cycle; TREADY returns 1 in the cycle after the pop.
REQ-023 Pop occurs on an edge where rd_en=1 and rd_valid=1; rd_en while rd_valid=0 is ignored, no state change.
REQ-024 Write-to-read latency: beat accepted at edge N is visible on rd_* with rd_valid=1 after edge N (empty FIFO).
REQ-025 Simultaneous push and pop: both performed; level unchanged; valid at any level 1..DEPTH-1, and at level 0 only the push takes effect.
REQ-026 Pointers are clog2(DEPTH) bits and wrap modulo DEPTH; level increments/decrements by 1, never exceeds DEPTH, never below 0.
REQ-027 FSM states IDLE and BODY: IDLE -> BODY on accepted beat with TLAST=0; BODY -> IDLE on accepted beat with TLAST=1; otherwise hold; accepted TLAST=1 beat in IDLE is a single-beat packet and stays IDLE.
REQ-028 Byte accumulator: on each accepted beat add popcount(TSTRB); cleared when the packet's last beat is accepted; TSTRB=0 beats are stored and add 0.
REQ-029 Accumulator and pkt_bytes saturate at 16'hFFFF; no wrap.
REQ-030 Error flag: set by any accepted beat with TUSER=1; cleared with the accumulator.
REQ-031 On the edge accepting a TLAST=1 beat: pkt_bytes <= accumulator + popcount(TSTRB) (saturated); pkt_err <= flag OR TUSER; pkt_done=1 for exactly the following cycle.
REQ-032 Back-to-back last beats on consecutive edges produce pkt_done on consecutive cycles, each with its own pkt_bytes/pkt_err.
REQ-033 Packet accounting is independent of the read side; pkt_done is not delayed by rd_en.

Reset
REQ-034 ARESETn=0 forces immediately, without waiting for ACLK: FSM=IDLE, pointers=0, level=0, TREADY=1 only after reset release (0 while ARESETn=0), rd_valid=0, pkt_done=0, pkt_bytes=0, pkt_err=0, accumulator=0, flag=0.
REQ-035 Reset mid-packet discards stored entries and the partial packet; no pkt_done is generated for it.
REQ-036 rd_data/rd_strb/rd_last are don't-care while rd_valid=0.

Verification
REQ-037 Single beat TDATA=0xA5A5A5A5, TSTRB=0xF, TLAST=1 into empty FIFO -> rd_valid=1 next cycle with rd_data=0xA5A5A5A5, rd_last=1; pkt_done=1 with pkt_bytes=4, pkt_err=0.
REQ-038 Four beats TSTRB=F,F,F,3, TUSER=1 on beat 2, rd_en=0 -> pkt_bytes=14, pkt_err=1, level=4.
REQ-039 Fill DEPTH=16 beats with rd_en=0 -> TREADY=0 at level=16; assert rd_en for one cycle -> level=15, TREADY=1 one cycle later; 17th beat accepted and read back in order.
REQ-040 Continuous TVALID=1 and rd_en=1 for 100 beats at level 5 -> level stays 5, pointers wrap, data order preserved.
REQ-041 ARESETn pulsed low after 2 beats of a 4-beat packet -> level=0, rd_valid=0, no pkt_done; next 1-beat packet with TSTRB=0x1 reports pkt_bytes=1.
REQ-042 Packet of 16400 beats, TSTRB=0xF -> pkt_bytes=0xFFFF (saturated).
